tf_gen_lanes: RTL and testbench

Parametrised multi-lane twiddle-factor generator for the NWC NTT datapath. Each of NUM_LANES lanes holds a base twiddle and two per-lane step constants, forward and inverse. On start, the block emits step_cnt successive twiddle vectors. Vector k carries base·const^k mod modulus in every lane, and each vector is delivered over a valid/ready handshake to the butterfly array. This is the next generation of the fixed 15-lane generator: lane count, width and multiplier latency are parameters, and the block adds an inverse mode, backpressure and a programmable step count.

---
 rtl/tf_gen_lanes.sv | 195 +++++++++++++++++++
 tb/tb_tf_gen_lanes.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tf_gen_lanes.sv
// Multi-lane twiddle-factor generator: emits step_cnt vectors base*const^k mod q
// over a valid/ready handshake, with forward/inverse constant tables.
module tf_gen_lanes #(
  parameter int unsigned NUM_LANES = 15,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned CNT_W     = 8,
  parameter int unsigned MUL_LAT   = 3,
  localparam int unsigned LANE_W   = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cfg_we,
  input  logic [1:0]                    cfg_sel,
  input  logic [LANE_W-1:0]             cfg_lane,
  input  logic [DATA_W-1:0]             cfg_data,
  input  logic [DATA_W-1:0]             modulus,
  input  logic                          start,
  input  logic                          inv_mode,
  input  logic [CNT_W-1:0]              step_cnt,
  output logic                          busy,
  output logic                          done,
  output logic                          tf_valid,
  input  logic                          tf_ready,
  output logic [NUM_LANES*DATA_W-1:0]   tf_data,
  output logic [CNT_W-1:0]              tf_idx
);

  localparam int unsigned PROD_W = 2 * DATA_W;
  localparam int unsigned LAT_W  = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_EMIT, S_MUL, S_FIN} state_e;

  state_e                    state_q, state_d;
  logic [DATA_W-1:0]         base_tab_q [NUM_LANES];
  logic [DATA_W-1:0]         base_tab_d [NUM_LANES];
  logic [DATA_W-1:0]         fwd_tab_q  [NUM_LANES];
  logic [DATA_W-1:0]         fwd_tab_d  [NUM_LANES];
  logic [DATA_W-1:0]         inv_tab_q  [NUM_LANES];
  logic [DATA_W-1:0]         inv_tab_d  [NUM_LANES];
  logic [DATA_W-1:0]         work_q     [NUM_LANES];
  logic [DATA_W-1:0]         work_d     [NUM_LANES];
  logic [PROD_W-1:0]         pipe_q     [MUL_LAT][NUM_LANES];
  logic [PROD_W-1:0]         pipe_d     [MUL_LAT][NUM_LANES];
  logic [CNT_W-1:0]          remaining_q, remaining_d;
  logic [CNT_W-1:0]          idx_q, idx_d;
  logic [LAT_W-1:0]          mul_cnt_q, mul_cnt_d;
  logic                      inv_mode_q, inv_mode_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;
  logic                      tf_valid_q, tf_valid_d;
  logic [NUM_LANES*DATA_W-1:0] tf_data_q, tf_data_d;
  logic [CNT_W-1:0]          tf_idx_q, tf_idx_d;

  // Next-state, table, datapath and registered-output computation
  always_comb begin
    state_d     = state_q;
    base_tab_d  = base_tab_q;
    fwd_tab_d   = fwd_tab_q;
    inv_tab_d   = inv_tab_q;
    work_d      = work_q;
    remaining_d = remaining_q;
    idx_d       = idx_q;
    mul_cnt_d   = mul_cnt_q;
    inv_mode_d  = inv_mode_q;

    // Product pipe free-runs; work is stable in EMIT/MUL so the stage-0 sample
    // taken at the handshake edge is the one reduced at the end of MUL.
    for (int i = 0; i < NUM_LANES; i++) begin
      pipe_d[0][i] = PROD_W'(work_q[i]) *
                     PROD_W'(inv_mode_q ? inv_tab_q[i] : fwd_tab_q[i]);
    end
    for (int s = 1; s < MUL_LAT; s++) begin
      pipe_d[s] = pipe_q[s-1];
    end

    case (state_q)
      S_IDLE: begin
        if (cfg_we) begin
          for (int i = 0; i < NUM_LANES; i++) begin
            if (cfg_lane == LANE_W'(i)) begin
              case (cfg_sel)
                2'd0:    base_tab_d[i] = cfg_data;
                2'd1:    fwd_tab_d[i]  = cfg_data;
                2'd2:    inv_tab_d[i]  = cfg_data;
                default: ;
              endcase
            end
          end
        end
        if (start) begin
          if (step_cnt == '0) begin
            state_d = S_FIN;
          end else begin
            work_d      = base_tab_q;
            inv_mode_d  = inv_mode;
            remaining_d = step_cnt;
            idx_d       = '0;
            state_d     = S_EMIT;
          end
        end
      end
      S_EMIT: begin
        if (tf_ready) begin
          if (remaining_q == CNT_W'(1)) begin
            state_d = S_FIN;
          end else begin
            remaining_d = remaining_q - CNT_W'(1);
            idx_d       = idx_q + CNT_W'(1);
            mul_cnt_d   = '0;
            state_d     = S_MUL;
          end
        end
      end
      S_MUL: begin
        if (mul_cnt_q == LAT_W'(MUL_LAT - 1)) begin
          for (int i = 0; i < NUM_LANES; i++) begin
            work_d[i] = DATA_W'(pipe_q[MUL_LAT-1][i] % PROD_W'(modulus));
          end
          state_d = S_EMIT;
        end else begin
          mul_cnt_d = mul_cnt_q + LAT_W'(1);
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d     = (state_d == S_EMIT) || (state_d == S_MUL);
    done_d     = (state_d == S_FIN);
    tf_valid_d = (state_d == S_EMIT);
    tf_idx_d   = idx_d;
    tf_data_d  = '0;
    if (state_d == S_EMIT) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        tf_data_d[i*DATA_W +: DATA_W] = work_d[i];
      end
    end
  end

  // State, storage and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      remaining_q <= '0;
      idx_q       <= '0;
      mul_cnt_q   <= '0;
      inv_mode_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      tf_valid_q  <= 1'b0;
      tf_data_q   <= '0;
      tf_idx_q    <= '0;
      for (int i = 0; i < NUM_LANES; i++) begin
        base_tab_q[i] <= '0;
        fwd_tab_q[i]  <= '0;
        inv_tab_q[i]  <= '0;
        work_q[i]     <= '0;
        for (int s = 0; s < MUL_LAT; s++) begin
          pipe_q[s][i] <= '0;
        end
      end
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      idx_q       <= idx_d;
      mul_cnt_q   <= mul_cnt_d;
      inv_mode_q  <= inv_mode_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      tf_valid_q  <= tf_valid_d;
      tf_data_q   <= tf_data_d;
      tf_idx_q    <= tf_idx_d;
      for (int i = 0; i < NUM_LANES; i++) begin
        base_tab_q[i] <= base_tab_d[i];
        fwd_tab_q[i]  <= fwd_tab_d[i];
        inv_tab_q[i]  <= inv_tab_d[i];
        work_q[i]     <= work_d[i];
        for (int s = 0; s < MUL_LAT; s++) begin
          pipe_q[s][i] <= pipe_d[s][i];
        end
      end
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign tf_valid = tf_valid_q;
  assign tf_data  = tf_data_q;
  assign tf_idx   = tf_idx_q;

endmodule

// File: tb/tb_tf_gen_lanes.sv
// Directed bench for tf_gen_lanes: small 2-lane instance with hand-computed
// vectors, plus 15-lane and 1-lane instances checked against a pow-mod model.
module tb_tf_gen_lanes;

  localparam logic [63:0] Q = 64'h7FFF_FFFF;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_err = 0;
  int   last_cyc = 0;

  // 2-lane directed instance
  logic        a_we, a_start, a_inv, a_ready;
  logic [1:0]  a_sel;
  logic [0:0]  a_lane;
  logic [31:0] a_data_in, a_mod;
  logic [7:0]  a_step;
  logic        a_busy, a_done, a_valid;
  logic [63:0] a_data;
  logic [7:0]  a_idx;

  // Shared stimulus for the sweep instances
  logic [1:0]  s_sel;
  logic [31:0] s_data, s_mod;
  logic        s_inv, s_ready;
  logic [7:0]  s_step;

  logic         b_we, b_start, b_busy, b_done, b_valid;
  logic [3:0]   b_lane;
  logic [479:0] b_data;
  logic [7:0]   b_idx;

  logic         c_we, c_start, c_busy, c_done, c_valid;
  logic [0:0]   c_lane;
  logic [31:0]  c_data;
  logic [7:0]   c_idx;

  tf_gen_lanes #(.NUM_LANES(2), .DATA_W(32), .CNT_W(8), .MUL_LAT(3)) u_a (
    .clk(clk), .rst(rst), .cfg_we(a_we), .cfg_sel(a_sel), .cfg_lane(a_lane),
    .cfg_data(a_data_in), .modulus(a_mod), .start(a_start), .inv_mode(a_inv),
    .step_cnt(a_step), .busy(a_busy), .done(a_done), .tf_valid(a_valid),
    .tf_ready(a_ready), .tf_data(a_data), .tf_idx(a_idx)
  );

  tf_gen_lanes #(.NUM_LANES(15), .DATA_W(32), .CNT_W(8), .MUL_LAT(4)) u_b (
    .clk(clk), .rst(rst), .cfg_we(b_we), .cfg_sel(s_sel), .cfg_lane(b_lane),
    .cfg_data(s_data), .modulus(s_mod), .start(b_start), .inv_mode(s_inv),
    .step_cnt(s_step), .busy(b_busy), .done(b_done), .tf_valid(b_valid),
    .tf_ready(s_ready), .tf_data(b_data), .tf_idx(b_idx)
  );

  tf_gen_lanes #(.NUM_LANES(1), .DATA_W(32), .CNT_W(8), .MUL_LAT(1)) u_c (
    .clk(clk), .rst(rst), .cfg_we(c_we), .cfg_sel(s_sel), .cfg_lane(c_lane),
    .cfg_data(s_data), .modulus(s_mod), .start(c_start), .inv_mode(s_inv),
    .step_cnt(s_step), .busy(c_busy), .done(c_done), .tf_valid(c_valid),
    .tf_ready(s_ready), .tf_data(c_data), .tf_idx(c_idx)
  );

  always #5 clk = ~clk;

  // Edge counter used to measure vector spacing
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] mulmod(input logic [63:0] a, input logic [63:0] b,
                                         input logic [63:0] q);
    return (a * b) % q;
  endfunction

  function automatic logic [63:0] powmod(input logic [63:0] c, input int k,
                                         input logic [63:0] q);
    logic [63:0] r, bb;
    int e;
    r = 64'd1; bb = c; e = k;
    while (e > 0) begin
      if (e[0]) r = mulmod(r, bb, q);
      bb = mulmod(bb, bb, q);
      e = e >> 1;
    end
    return r;
  endfunction

  task automatic a_cfg(input logic [1:0] sel, input logic [0:0] lane, input logic [31:0] d);
    a_we = 1'b1; a_sel = sel; a_lane = lane; a_data_in = d;
    tick();
    a_we = 1'b0;
  endtask

  // Start pulse, then scramble mode/count to show they are latched at start
  task automatic a_run(input logic inv, input logic [7:0] cnt);
    a_inv = inv; a_step = cnt; a_start = 1'b1;
    tick();
    a_start = 1'b0; a_inv = ~inv; a_step = 8'd7;
  endtask

  task automatic a_vec(input string tag, input int k, input logic [31:0] e0,
                       input logic [31:0] e1, input bit sp, input bit take);
    for (int n = 0; n < 30 && !a_valid; n++) tick();
    chk({tag, "_valid"}, 64'(a_valid), 64'd1);
    if (sp) chk({tag, "_gap"}, 64'(cyc - last_cyc), 64'd4);
    last_cyc = cyc;
    chk({tag, "_busy"}, 64'(a_busy), 64'd1);
    chk({tag, "_idx"}, 64'(a_idx), 64'(k));
    chk({tag, "_l0"}, 64'(a_data[31:0]), 64'(e0));
    chk({tag, "_l1"}, 64'(a_data[63:32]), 64'(e1));
    if (take) tick();
  endtask

  task automatic a_fin(input string tag);
    chk({tag, "_done"}, 64'(a_done), 64'd1);
    chk({tag, "_busy"}, 64'(a_busy), 64'd0);
    chk({tag, "_vld"}, 64'(a_valid), 64'd0);
    chk({tag, "_data"}, a_data, 64'd0);
    tick();
    chk({tag, "_done2"}, 64'(a_done), 64'd0);
  endtask

  task automatic sweep_b();
    logic [31:0] bs [15];
    logic [31:0] cs [15];
    s_mod = 32'(Q);
    for (int i = 0; i < 15; i++) begin
      bs[i] = 32'($urandom_range(1, 32'h7FFF_FFFE));
      cs[i] = 32'($urandom_range(1, 32'h7FFF_FFFE));
    end
    b_we = 1'b1;
    for (int i = 0; i < 15; i++) begin
      b_lane = 4'(i);
      s_sel = 2'd0; s_data = bs[i]; tick();
      s_sel = 2'd1; s_data = cs[i]; tick();
    end
    b_we = 1'b0;
    s_inv = 1'b0; s_step = 8'd16; b_start = 1'b1;
    tick();
    b_start = 1'b0;
    for (int k = 0; k < 16; k++) begin
      for (int n = 0; n < 30 && !b_valid; n++) tick();
      chk("b_valid", 64'(b_valid), 64'd1);
      chk("b_idx", 64'(b_idx), 64'(k));
      for (int i = 0; i < 15; i++) begin
        chk("b_lane", 64'(b_data[i*32 +: 32]),
            mulmod(64'(bs[i]), powmod(64'(cs[i]), k, Q), Q));
      end
      tick();
    end
    chk("b_done", 64'(b_done), 64'd1);
  endtask

  task automatic sweep_c();
    logic [31:0] bs, cs;
    s_mod = 32'(Q);
    bs = 32'($urandom_range(1, 32'h7FFF_FFFE));
    cs = 32'($urandom_range(1, 32'h7FFF_FFFE));
    c_we = 1'b1; c_lane = 1'b0;
    s_sel = 2'd0; s_data = bs; tick();
    s_sel = 2'd2; s_data = cs; tick();
    c_we = 1'b0;
    s_inv = 1'b1; s_step = 8'd16; c_start = 1'b1;
    tick();
    c_start = 1'b0;
    for (int k = 0; k < 16; k++) begin
      for (int n = 0; n < 30 && !c_valid; n++) tick();
      chk("c_valid", 64'(c_valid), 64'd1);
      chk("c_idx", 64'(c_idx), 64'(k));
      chk("c_lane", 64'(c_data), mulmod(64'(bs), powmod(64'(cs), k, Q), Q));
      tick();
    end
    chk("c_done", 64'(c_done), 64'd1);
  endtask

  initial begin
    bit seen;
    rst = 1'b1;
    a_we = 1'b0; a_start = 1'b0; a_inv = 1'b0; a_ready = 1'b1;
    a_sel = 2'd0; a_lane = 1'b0; a_data_in = 32'd0; a_mod = 32'd17; a_step = 8'd0;
    s_sel = 2'd0; s_data = 32'd0; s_mod = 32'(Q); s_inv = 1'b0; s_ready = 1'b1;
    s_step = 8'd0;
    b_we = 1'b0; b_start = 1'b0; b_lane = 4'd0;
    c_we = 1'b0; c_start = 1'b0; c_lane = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("rst_busy", 64'(a_busy), 64'd0);
    chk("rst_done", 64'(a_done), 64'd0);
    chk("rst_vld", 64'(a_valid), 64'd0);
    chk("rst_data", a_data, 64'd0);
    chk("rst_idx", 64'(a_idx), 64'd0);

    // Load tables; the reserved select must not disturb anything
    a_cfg(2'd0, 1'b0, 32'd1);  a_cfg(2'd0, 1'b1, 32'd2);
    a_cfg(2'd1, 1'b0, 32'd3);  a_cfg(2'd1, 1'b1, 32'd4);
    a_cfg(2'd2, 1'b0, 32'd6);  a_cfg(2'd2, 1'b1, 32'd13);
    a_cfg(2'd3, 1'b0, 32'd11);

    // Forward run
    a_run(1'b0, 8'd3);
    chk("fwd_start_vld", 64'(a_valid), 64'd1);
    a_vec("f0", 0, 32'd1, 32'd2, 1'b0, 1'b1);
    chk("fwd_gap_vld", 64'(a_valid), 64'd0);
    chk("fwd_gap_data", a_data, 64'd0);
    chk("fwd_gap_busy", 64'(a_busy), 64'd1);
    a_vec("f1", 1, 32'd3, 32'd8, 1'b1, 1'b1);
    a_vec("f2", 2, 32'd9, 32'd15, 1'b1, 1'b1);
    a_fin("fwd_fin");

    // Inverse run, then forward replay without reloading
    a_run(1'b1, 8'd2);
    a_vec("i0", 0, 32'd1, 32'd2, 1'b0, 1'b1);
    a_vec("i1", 1, 32'd6, 32'd9, 1'b1, 1'b1);
    a_fin("inv_fin");
    a_run(1'b0, 8'd2);
    a_vec("r0", 0, 32'd1, 32'd2, 1'b0, 1'b1);
    a_vec("r1", 1, 32'd3, 32'd8, 1'b1, 1'b1);
    a_fin("rep_fin");

    // Backpressure on vector 1
    a_run(1'b0, 8'd3);
    a_vec("bp0", 0, 32'd1, 32'd2, 1'b0, 1'b1);
    a_vec("bp1", 1, 32'd3, 32'd8, 1'b1, 1'b0);
    a_ready = 1'b0;
    for (int n = 0; n < 5; n++) begin
      tick();
      chk("bp_hold_vld", 64'(a_valid), 64'd1);
      chk("bp_hold_idx", 64'(a_idx), 64'd1);
      chk("bp_hold_data", a_data, {32'd8, 32'd3});
    end
    a_ready = 1'b1;
    tick();
    a_vec("bp2", 2, 32'd9, 32'd15, 1'b0, 1'b1);
    a_fin("bp_fin");

    // Zero step count
    a_run(1'b0, 8'd0);
    chk("z_done", 64'(a_done), 64'd1);
    chk("z_vld", 64'(a_valid), 64'd0);
    chk("z_busy", 64'(a_busy), 64'd0);
    tick();
    chk("z_done2", 64'(a_done), 64'd0);
    chk("z_vld2", 64'(a_valid), 64'd0);

    // Config write and start pulse while busy are ignored
    a_run(1'b0, 8'd3);
    a_vec("g0", 0, 32'd1, 32'd2, 1'b0, 1'b0);
    a_we = 1'b1; a_sel = 2'd0; a_lane = 1'b0; a_data_in = 32'd5;
    a_start = 1'b1; a_step = 8'd9;
    tick();
    a_we = 1'b0; a_start = 1'b0;
    a_vec("g1", 1, 32'd3, 32'd8, 1'b1, 1'b1);
    a_vec("g2", 2, 32'd9, 32'd15, 1'b1, 1'b1);
    a_fin("ign_fin");
    a_run(1'b0, 8'd1);
    a_vec("g_base", 0, 32'd1, 32'd2, 1'b0, 1'b1);
    a_fin("ign_fin2");

    // Reset during MUL of step 1
    a_run(1'b0, 8'd3);
    a_vec("m0", 0, 32'd1, 32'd2, 1'b0, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst_busy", 64'(a_busy), 64'd0);
    chk("mrst_done", 64'(a_done), 64'd0);
    chk("mrst_vld", 64'(a_valid), 64'd0);
    chk("mrst_data", a_data, 64'd0);
    chk("mrst_idx", 64'(a_idx), 64'd0);
    seen = 1'b0;
    for (int n = 0; n < 6; n++) begin
      tick();
      if (a_valid || a_done) seen = 1'b1;
    end
    chk("mrst_quiet", 64'(seen), 64'd0);
    // Tables were cleared by reset
    a_run(1'b0, 8'd1);
    a_vec("m_clr", 0, 32'd0, 32'd0, 1'b0, 1'b1);
    a_fin("clr_fin");
    a_cfg(2'd0, 1'b0, 32'd1);  a_cfg(2'd0, 1'b1, 32'd2);
    a_cfg(2'd1, 1'b0, 32'd3);  a_cfg(2'd1, 1'b1, 32'd4);
    a_run(1'b0, 8'd3);
    a_vec("n0", 0, 32'd1, 32'd2, 1'b0, 1'b1);
    a_vec("n1", 1, 32'd3, 32'd8, 1'b1, 1'b1);
    a_vec("n2", 2, 32'd9, 32'd15, 1'b1, 1'b1);
    a_fin("new_fin");

    // Parameter sweep against the pow-mod model
    sweep_b();
    tick();
    sweep_c();
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
